// File: rtl/riscv_alu_mc_pkg.sv
// riscv_alu_mc_pkg: op codes, FSM state encoding and op-class helpers for riscv_alu_mc
package riscv_alu_mc_pkg;
  localparam logic [4:0] ALU_CTRL_ADD    = 5'd0;
  localparam logic [4:0] ALU_CTRL_SUB    = 5'd1;
  localparam logic [4:0] ALU_CTRL_SLL    = 5'd2;
  localparam logic [4:0] ALU_CTRL_SLT    = 5'd3;
  localparam logic [4:0] ALU_CTRL_SLTU   = 5'd4;
  localparam logic [4:0] ALU_CTRL_XOR    = 5'd5;
  localparam logic [4:0] ALU_CTRL_SRL    = 5'd6;
  localparam logic [4:0] ALU_CTRL_SRA    = 5'd7;
  localparam logic [4:0] ALU_CTRL_OR     = 5'd8;
  localparam logic [4:0] ALU_CTRL_AND    = 5'd9;
  localparam logic [4:0] ALU_CTRL_MUL    = 5'd16;
  localparam logic [4:0] ALU_CTRL_MULH   = 5'd17;
  localparam logic [4:0] ALU_CTRL_MULHSU = 5'd18;
  localparam logic [4:0] ALU_CTRL_MULHU  = 5'd19;
  localparam logic [4:0] ALU_CTRL_DIV    = 5'd20;
  localparam logic [4:0] ALU_CTRL_DIVU   = 5'd21;
  localparam logic [4:0] ALU_CTRL_REM    = 5'd22;
  localparam logic [4:0] ALU_CTRL_REMU   = 5'd23;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_MUL = 2'd1, ST_DIV = 2'd2, ST_DONE = 2'd3} state_t;
  function automatic logic is_mul(input logic [4:0] op);
    return op[4:2] == 3'b100;
  endfunction
  function automatic logic is_div(input logic [4:0] op);
    return op[4:2] == 3'b101;
  endfunction
endpackage

// File: rtl/riscv_alu_mc_div.sv
// riscv_alu_mc_div: iterative restoring divider, XLEN steps on magnitudes then one sign fix-up cycle
// Ports: clk/rst_n (async active-low), start loads a/b and signed_op, abort cancels,
//        busy high while iterating or fixing up, done high in the fix-up cycle with quotient/remainder valid.
module riscv_alu_mc_div #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            signed_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);
  localparam int CW = $clog2(XLEN) + 1;
  logic            run, fix, neg_q, neg_r;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] rem, quo, dvs, a_mag, b_mag;
  logic [XLEN:0]   r_sh, diff;
  assign a_mag = (signed_op && a[XLEN-1]) ? -a : a;
  assign b_mag = (signed_op && b[XLEN-1]) ? -b : b;
  // partial remainder shifted left with the next dividend bit pulled in from the quotient register
  assign r_sh = {rem, quo[XLEN-1]};
  assign diff = r_sh - {1'b0, dvs};
  assign busy = run | fix;
  assign done = fix;
  assign quotient = neg_q ? -quo : quo;
  assign remainder = neg_r ? -rem : rem;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      fix <= 1'b0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= '0;
      dvs <= '0;
    end else if (abort) begin
      run <= 1'b0;
      fix <= 1'b0;
    end else if (start) begin
      run <= 1'b1;
      fix <= 1'b0;
      cnt <= '0;
      rem <= '0;
      quo <= a_mag;
      dvs <= b_mag;
      neg_q <= signed_op && (a[XLEN-1] ^ b[XLEN-1]);
      neg_r <= signed_op && a[XLEN-1];
    end else if (run) begin
      rem <= diff[XLEN] ? r_sh[XLEN-1:0] : diff[XLEN-1:0];
      quo <= {quo[XLEN-2:0], ~diff[XLEN]};
      cnt <= cnt + 1'b1;
      if (cnt == CW'(XLEN - 1)) begin
        run <= 1'b0;
        fix <= 1'b1;
      end
    end else if (fix) begin
      fix <= 1'b0;
    end
  end
endmodule

// File: rtl/riscv_alu_mc.sv
// riscv_alu_mc: multi-cycle RV32I/M execute ALU with valid/ready handshakes and flush
// Ports: i_clk, i_rstn (async active-low), i_flush; i_valid/o_ready accept side with i_alu_a, i_alu_b,
//        i_alu_ctrl, i_zero_condition; o_valid/i_ready result side with o_alu_result, o_alu_zero.
// Build option RISCV_ALU_MC_DIV_EN adds the divider; without it codes 20-23 behave as illegal ops.
module riscv_alu_mc
  import riscv_alu_mc_pkg::*;
#(
  parameter int XLEN = 32,
  localparam int SHW = $clog2(XLEN)
) (
  input  logic            i_clk,
  input  logic            i_rstn,
  input  logic            i_flush,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_alu_a,
  input  logic [XLEN-1:0] i_alu_b,
  input  logic [4:0]      i_alu_ctrl,
  input  logic            i_zero_condition,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_alu_result,
  output logic            o_alu_zero
);
  state_t            state;
  logic [4:0]        op_r;
  logic              zc_r, bsig, accept, div_go, b_zero, ovf, mul_last;
  logic [SHW:0]      cnt;
  logic [2*XLEN-1:0] acc, mcand, addend, acc_nxt, a_ext;
  logic [XLEN-1:0]   mplier, imm_res, mul_res, div_res;
  logic              div_busy, div_done;
  logic [SHW-1:0]    sh;
  function automatic logic zflag(input logic [XLEN-1:0] r, input logic zc);
    return zc ? |r : ~|r;
  endfunction
`ifdef RISCV_ALU_MC_DIV_EN
  localparam bit DIV_EN = 1'b1;
  logic [XLEN-1:0] div_q, div_r;
  riscv_alu_mc_div #(.XLEN(XLEN)) u_div (
    .clk(i_clk),
    .rst_n(i_rstn),
    .start(accept && div_go),
    .abort(i_flush),
    .signed_op(~i_alu_ctrl[0]),
    .a(i_alu_a),
    .b(i_alu_b),
    .busy(div_busy),
    .done(div_done),
    .quotient(div_q),
    .remainder(div_r)
  );
  assign div_res = op_r[1] ? div_r : div_q;
`else
  localparam bit DIV_EN = 1'b0;
  assign div_busy = 1'b0;
  assign div_done = 1'b0;
  assign div_res = '0;
`endif
  assign o_ready = (state == ST_IDLE) || (state == ST_DONE && i_ready);
  assign accept = i_valid && o_ready && !i_flush;
  assign sh = i_alu_b[SHW-1:0];
  assign b_zero = ~|i_alu_b;
  assign ovf = (i_alu_ctrl == ALU_CTRL_DIV || i_alu_ctrl == ALU_CTRL_REM) && i_alu_a == {1'b1, {(XLEN-1){1'b0}}} && &i_alu_b;
  // divide by zero and signed overflow resolve in one cycle through imm_res
  assign div_go = DIV_EN && is_div(i_alu_ctrl) && !b_zero && !ovf && !div_busy;
  assign a_ext = (i_alu_ctrl == ALU_CTRL_MULH || i_alu_ctrl == ALU_CTRL_MULHSU) ? {{XLEN{i_alu_a[XLEN-1]}}, i_alu_a} : {{XLEN{1'b0}}, i_alu_a};
  // signed multiplier: the top bit carries weight -2^(XLEN-1), so the last partial product is subtracted
  assign mul_last = cnt == (SHW+1)'(XLEN - 1);
  assign addend = mplier[0] ? mcand : '0;
  assign acc_nxt = (mul_last && bsig) ? acc - addend : acc + addend;
  assign mul_res = (op_r == ALU_CTRL_MUL) ? acc_nxt[XLEN-1:0] : acc_nxt[2*XLEN-1:XLEN];
  always_comb begin
    imm_res = '0;
    case (i_alu_ctrl)
      ALU_CTRL_ADD:  imm_res = i_alu_a + i_alu_b;
      ALU_CTRL_SUB:  imm_res = i_alu_a - i_alu_b;
      ALU_CTRL_SLL:  imm_res = i_alu_a << sh;
      ALU_CTRL_SLT:  imm_res = XLEN'($signed(i_alu_a) < $signed(i_alu_b));
      ALU_CTRL_SLTU: imm_res = XLEN'(i_alu_a < i_alu_b);
      ALU_CTRL_XOR:  imm_res = i_alu_a ^ i_alu_b;
      ALU_CTRL_SRL:  imm_res = i_alu_a >> sh;
      ALU_CTRL_SRA:  imm_res = $unsigned($signed(i_alu_a) >>> sh);
      ALU_CTRL_OR:   imm_res = i_alu_a | i_alu_b;
      ALU_CTRL_AND:  imm_res = i_alu_a & i_alu_b;
      ALU_CTRL_DIV, ALU_CTRL_DIVU: imm_res = DIV_EN ? (b_zero ? '1 : i_alu_a) : '0;
      ALU_CTRL_REM, ALU_CTRL_REMU: imm_res = (DIV_EN && b_zero) ? i_alu_a : '0;
      default:       imm_res = '0;
    endcase
  end
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state <= ST_IDLE;
      op_r <= '0;
      zc_r <= 1'b0;
      bsig <= 1'b0;
      cnt <= '0;
      acc <= '0;
      mcand <= '0;
      mplier <= '0;
      o_valid <= 1'b0;
      o_alu_result <= '0;
      o_alu_zero <= 1'b0;
    end else if (i_flush) begin
      state <= ST_IDLE;
      o_valid <= 1'b0;
    end else if (accept) begin
      op_r <= i_alu_ctrl;
      zc_r <= i_zero_condition;
      cnt <= '0;
      if (is_mul(i_alu_ctrl)) begin
        state <= ST_MUL;
        o_valid <= 1'b0;
        acc <= '0;
        mcand <= a_ext;
        mplier <= i_alu_b;
        bsig <= i_alu_ctrl == ALU_CTRL_MULH;
      end else if (div_go) begin
        state <= ST_DIV;
        o_valid <= 1'b0;
      end else begin
        state <= ST_DONE;
        o_valid <= 1'b1;
        o_alu_result <= imm_res;
        o_alu_zero <= zflag(imm_res, i_zero_condition);
      end
    end else if (state == ST_DONE && i_ready) begin
      state <= ST_IDLE;
      o_valid <= 1'b0;
    end else if (state == ST_MUL) begin
      acc <= acc_nxt;
      mcand <= mcand << 1;
      mplier <= mplier >> 1;
      cnt <= cnt + 1'b1;
      if (mul_last) begin
        state <= ST_DONE;
        o_valid <= 1'b1;
        o_alu_result <= mul_res;
        o_alu_zero <= zflag(mul_res, zc_r);
      end
    end else if (state == ST_DIV && div_done) begin
      state <= ST_DONE;
      o_valid <= 1'b1;
      o_alu_result <= div_res;
      o_alu_zero <= zflag(div_res, zc_r);
    end
  end
endmodule

// File: tb/tb_riscv_alu_mc.sv
// tb_riscv_alu_mc: randomized and directed checks of riscv_alu_mc against an arithmetic reference model
module tb_riscv_alu_mc;
  logic        clk = 1'b0, rstn = 1'b0, flush = 1'b0, vin = 1'b0, rdy = 1'b0, zc = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic [4:0]  ctrl = '0;
  logic        ready, vout, zero;
  logic [31:0] res;
  int          n_chk = 0, n_fail = 0;
  logic [31:0] pool [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};
`ifdef RISCV_ALU_MC_DIV_EN
  localparam bit DIV_EN = 1'b1;
  `define DV(x) (x)
  `define DL(n) (n)
`else
  localparam bit DIV_EN = 1'b0;
  `define DV(x) 32'h0
  `define DL(n) 1
`endif
  riscv_alu_mc #(.XLEN(32)) dut (
    .i_clk(clk),
    .i_rstn(rstn),
    .i_flush(flush),
    .i_valid(vin),
    .o_ready(ready),
    .i_alu_a(a),
    .i_alu_b(b),
    .i_alu_ctrl(ctrl),
    .i_zero_condition(zc),
    .o_valid(vout),
    .i_ready(rdy),
    .o_alu_result(res),
    .o_alu_zero(zero)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] ref_res(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    int sx = x;
    int sy = y;
    longint p;
    logic [63:0] u;
    logic ov = (x == 32'h80000000) && (y == 32'hFFFFFFFF);
    case (op)
      0: return x + y;
      1: return x - y;
      2: return x << y[4:0];
      3: return {31'b0, sx < sy};
      4: return {31'b0, x < y};
      5: return x ^ y;
      6: return x >> y[4:0];
      7: return 32'(sx >>> y[4:0]);
      8: return x | y;
      9: return x & y;
      16: return x * y;
      17: begin p = longint'(sx) * longint'(sy); return p[63:32]; end
      18: begin p = longint'(sx) * longint'({32'b0, y}); return p[63:32]; end
      19: begin u = {32'b0, x} * {32'b0, y}; return u[63:32]; end
      20: return !DIV_EN ? 32'h0 : (y == 0) ? 32'hFFFFFFFF : ov ? x : 32'(sx / sy);
      21: return !DIV_EN ? 32'h0 : (y == 0) ? 32'hFFFFFFFF : x / y;
      22: return !DIV_EN ? 32'h0 : (y == 0) ? x : ov ? 32'h0 : 32'(sx % sy);
      23: return !DIV_EN ? 32'h0 : (y == 0) ? x : x % y;
      default: return 32'h0;
    endcase
  endfunction
  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y);
    if (op >= 16 && op <= 19) return 33;
    if (DIV_EN && op >= 20 && op <= 23 && y != 0 && !((op == 20 || op == 22) && x == 32'h80000000 && y == 32'hFFFFFFFF)) return 34;
    return 1;
  endfunction
  task automatic do_op(input string tag, input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                       input logic z, input logic [31:0] er, input int el);
    int lat;
    @(negedge clk);
    check({tag, "/ready"}, 64'(ready), 64'd1);
    ctrl = op; a = x; b = y; zc = z; vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    lat = 1;
    while (!vout && lat < 200) begin
      @(posedge clk);
      #1 lat++;
    end
    check({tag, "/lat"}, 64'(lat), 64'(el));
    check({tag, "/res"}, 64'(res), 64'(er));
    check({tag, "/zero"}, 64'(zero), 64'(z ? (er != 0) : (er == 0)));
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    check({tag, "/drop"}, 64'(vout), 64'd0);
  endtask
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    logic seen;
    logic [4:0] op;
    logic [31:0] x, y;
    logic z;
    #12;
    check("rst/valid", 64'(vout), 64'd0);
    check("rst/result", 64'(res), 64'd0);
    check("rst/zero", 64'(zero), 64'd0);
    check("rst/ready", 64'(ready), 64'd1);
    @(negedge clk) rstn = 1'b1;
    do_op("add", 5'd0, 32'h7FFFFFFF, 32'h1, 1'b0, 32'h80000000, 1);
    do_op("sra", 5'd7, 32'h80000000, 32'd31, 1'b0, 32'hFFFFFFFF, 1);
    do_op("slt", 5'd3, 32'hFFFFFFFF, 32'h1, 1'b0, 32'h1, 1);
    do_op("mulh", 5'd17, 32'hFFFFFFFE, 32'd3, 1'b0, 32'hFFFFFFFF, 33);
    do_op("mulhu", 5'd19, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 32'hFFFFFFFE, 33);
    do_op("div", 5'd20, 32'hFFFFFFF9, 32'd2, 1'b0, `DV(32'hFFFFFFFD), `DL(34));
    do_op("rem", 5'd22, 32'hFFFFFFF9, 32'd2, 1'b0, `DV(32'hFFFFFFFF), `DL(34));
    do_op("divu0", 5'd21, 32'd5, 32'd0, 1'b0, `DV(32'hFFFFFFFF), 1);
    do_op("rem0", 5'd22, 32'd5, 32'd0, 1'b0, `DV(32'd5), 1);
    do_op("divovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 1'b0, `DV(32'h80000000), 1);
    do_op("illegal", 5'd12, 32'h1234, 32'h5678, 1'b1, 32'h0, 1);
    do_op("subz", 5'd1, 32'd5, 32'd5, 1'b1, 32'h0, 1);
    @(negedge clk);
    ctrl = 5'd0; a = 32'd3; b = 32'd4; zc = 1'b0; vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    check("hold/first", {31'b0, vout, res}, {31'b0, 1'b1, 32'd7});
    repeat (5) begin
      @(posedge clk);
      #1 check("hold", {31'b0, vout, res}, {31'b0, 1'b1, 32'd7});
    end
    @(negedge clk);
    #2 rstn = 1'b0;
    #1;
    check("async_rst/valid", 64'(vout), 64'd0);
    check("async_rst/result", 64'(res), 64'd0);
    check("async_rst/ready", 64'(ready), 64'd1);
    @(negedge clk) rstn = 1'b1;
    @(negedge clk);
    ctrl = 5'd16; a = 32'd9; b = 32'd9; vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk) flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    check("flush/valid", 64'(vout), 64'd0);
    check("flush/ready", 64'(ready), 64'd1);
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1 if (vout) seen = 1'b1;
    end
    check("flush/never_valid", 64'(seen), 64'd0);
    @(negedge clk);
    ctrl = 5'd0; a = 32'd1; b = 32'd1; flush = 1'b1; vin = 1'b1;
    @(posedge clk);
    #1 begin flush = 1'b0; vin = 1'b0; end
    seen = vout;
    repeat (3) begin
      @(posedge clk);
      #1 if (vout) seen = 1'b1;
    end
    check("flush_prio", 64'(seen), 64'd0);
    @(negedge clk);
    ctrl = 5'd0; a = 32'd1; b = 32'd2; zc = 1'b0; vin = 1'b1;
    @(posedge clk);
    #1 vin = 1'b0;
    check("b2b/first", {31'b0, vout, res}, {31'b0, 1'b1, 32'd3});
    @(negedge clk);
    rdy = 1'b1; ctrl = 5'd5; a = 32'd5; b = 32'd9; vin = 1'b1;
    #1 check("b2b/ready", 64'(ready), 64'd1);
    @(posedge clk);
    #1 begin vin = 1'b0; rdy = 1'b0; end
    check("b2b/second", {31'b0, vout, res}, {31'b0, 1'b1, 32'hC});
    rdy = 1'b1;
    @(posedge clk);
    #1 rdy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      op = 5'($urandom_range(0, 31));
      x = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      y = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 7) == 0) y = 32'h0;
      z = 1'($urandom_range(0, 1));
      do_op($sformatf("rnd%0d_op%0d", i, op), op, x, y, z, ref_res(op, x, y), ref_lat(op, x, y));
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
